// File: rtl/sfq_alu_pipe.sv
// Pipelined WIDTH-bit ALU: AND/XOR/ADD with operand complement, valid-tagged
// STAGES-deep result pipe, overflow flag and a carry register for multi-word arithmetic.
module sfq_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic             cmpl_x,
  input  logic             cmpl_y,
  input  logic             carry_in,
  input  logic             chain,
  input  logic             op_and,
  input  logic             op_xor,
  input  logic             op_arith,
  output logic             out_valid,
  output logic [WIDTH-1:0] zout,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] x_op, y_op, lo_sum, z_next;
  logic [1:0]       msb_sum;
  logic             cin, c_top, co_next, ov_next;
  logic             cy_q;

  logic             v_q  [STAGES];
  logic [WIDTH-1:0] z_q  [STAGES];
  logic             co_q [STAGES];
  logic             ov_q [STAGES];

  // The add is split below the MSB so the carry into the MSB is visible for overflow.
  always_comb begin
    x_op    = xin ^ {WIDTH{cmpl_x}};
    y_op    = yin ^ {WIDTH{cmpl_y}};
    cin     = chain ? cy_q : carry_in;
    lo_sum  = {1'b0, x_op[WIDTH-2:0]} + {1'b0, y_op[WIDTH-2:0]} + WIDTH'(cin);
    msb_sum = 2'(x_op[WIDTH-1]) + 2'(y_op[WIDTH-1]) + 2'(lo_sum[WIDTH-1]);
    c_top   = msb_sum[1];
    z_next  = '0;
    if (op_and)   z_next = z_next | (x_op & y_op);
    if (op_xor)   z_next = z_next | (x_op ^ y_op);
    if (op_arith) z_next = z_next | {msb_sum[0], lo_sum[WIDTH-2:0]};
    co_next = op_arith & c_top;
    ov_next = op_arith & (c_top ^ lo_sum[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy_q <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        v_q[i]  <= 1'b0;
        z_q[i]  <= '0;
        co_q[i] <= 1'b0;
        ov_q[i] <= 1'b0;
      end
    end else begin
      if (in_valid && op_arith) cy_q <= c_top;
      // Bubbles enter as all-zero so outputs need no gating at the pipe end.
      v_q[0]  <= in_valid;
      z_q[0]  <= in_valid ? z_next : '0;
      co_q[0] <= in_valid & co_next;
      ov_q[0] <= in_valid & ov_next;
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_q[i]  <= v_q[i-1];
        z_q[i]  <= z_q[i-1];
        co_q[i] <= co_q[i-1];
        ov_q[i] <= ov_q[i-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign zout      = z_q[STAGES-1];
  assign carry_out = co_q[STAGES-1];
  assign overflow  = ov_q[STAGES-1];

endmodule

// File: tb/tb_sfq_alu_pipe.sv
// Bench for sfq_alu_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_sfq_alu_pipe;
  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, cmpl_x = 1'b0, cmpl_y = 1'b0, carry_in = 1'b0, chain = 1'b0;
  logic op_and = 1'b0, op_xor = 1'b0, op_arith = 1'b0;
  logic [W-1:0] xin = '0, yin = '0;
  logic out_valid, carry_out, overflow;
  logic [W-1:0] zout;

  int checks = 0, errors = 0;

  sfq_alu_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .xin(xin), .yin(yin),
    .cmpl_x(cmpl_x), .cmpl_y(cmpl_y), .carry_in(carry_in), .chain(chain),
    .op_and(op_and), .op_xor(op_xor), .op_arith(op_arith),
    .out_valid(out_valid), .zout(zout), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] z;
    logic         c;
    logic         o;
  } res_t;

  res_t pipe_q[$];
  logic mdl_cy = 1'b0;

  // Reference model: one entry per clock edge; the oldest of S entries is the output.
  always @(negedge rst_n) begin
    pipe_q.delete();
    mdl_cy = 1'b0;
  end

  always @(posedge clk) begin
    res_t r;
    logic [W-1:0] xa, ya;
    logic [W:0]   s;
    int           cin;
    if (!rst_n) begin
      pipe_q.delete();
      mdl_cy = 1'b0;
    end else begin
      r  = '{1'b0, '0, 1'b0, 1'b0};
      xa = cmpl_x ? ~xin : xin;
      ya = cmpl_y ? ~yin : yin;
      cin = chain ? int'(mdl_cy) : int'(carry_in);
      s  = (W+1)'(int'(xa) + int'(ya) + cin);
      if (in_valid) begin
        r.v = 1'b1;
        if (op_and)   r.z = r.z | (xa & ya);
        if (op_xor)   r.z = r.z | (xa ^ ya);
        if (op_arith) begin
          r.z = r.z | s[W-1:0];
          r.c = s[W];
          r.o = (xa[W-1] == ya[W-1]) && (s[W-1] != xa[W-1]);
          mdl_cy = s[W];
        end
      end
      pipe_q.push_back(r);
      if (pipe_q.size() > S) void'(pipe_q.pop_front());
    end
  end

  always @(negedge clk) begin
    res_t e;
    e = '{1'b0, '0, 1'b0, 1'b0};
    if (pipe_q.size() == S) e = pipe_q[0];
    checks++;
    if ({out_valid, zout, carry_out, overflow} !== {e.v, e.z, e.c, e.o}) begin
      errors++;
      $display("FAIL model t=%0t got v=%b z=%h c=%b o=%b required v=%b z=%h c=%b o=%b",
               $time, out_valid, zout, carry_out, overflow, e.v, e.z, e.c, e.o);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic cx, input logic cy, input logic ci, input logic ch,
                       input logic a, input logic xo, input logic ar);
    @(posedge clk);
    #2;
    in_valid = v; xin = x; yin = y; cmpl_x = cx; cmpl_y = cy; carry_in = ci;
    chain = ch; op_and = a; op_xor = xo; op_arith = ar;
  endtask

  task automatic idle();
    drive(1'b0, W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic lit(input string name, input logic v, input logic [W-1:0] z,
                     input logic c, input logic o);
    checks++;
    if ({out_valid, zout, carry_out, overflow} !== {v, z, c, o}) begin
      errors++;
      $display("FAIL %s got v=%b z=%h c=%b o=%b required v=%b z=%h c=%b o=%b",
               name, out_valid, zout, carry_out, overflow, v, z, c, o);
    end
  endtask

  // After the last drive returns, k-th result appears at the negedge following posedge n.
  task automatic wait_out(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Inputs toggling under reset must not disturb the outputs.
    for (int i = 0; i < 6; i++)
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b1, 1'b1, 1'b1);
    @(negedge clk); lit("reset_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    wait_out(2); lit("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    drive(1'b1, 8'h7F, 8'h01, 0, 0, 0, 0, 0, 0, 1);
    idle();
    wait_out(3); lit("add_overflow", 1'b1, 8'h80, 1'b0, 1'b1);
    wait_out(1); lit("single_cycle_valid", 1'b0, 8'h00, 1'b0, 1'b0);

    drive(1'b1, 8'h05, 8'h07, 0, 1, 1, 0, 0, 0, 1);
    drive(1'b1, 8'h07, 8'h05, 0, 1, 1, 0, 0, 0, 1);
    idle();
    wait_out(2); lit("sub_neg", 1'b1, 8'hFE, 1'b0, 1'b0);
    wait_out(1); lit("sub_pos", 1'b1, 8'h02, 1'b1, 1'b0);

    drive(1'b1, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 1);
    drive(1'b1, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0, 1);
    idle();
    wait_out(2); lit("chain_lo", 1'b1, 8'h00, 1'b1, 1'b0);
    wait_out(1); lit("chain_hi", 1'b1, 8'h02, 1'b0, 1'b0);

    drive(1'b1, 8'hF0, 8'h3C, 0, 0, 1, 0, 1, 1, 0);
    drive(1'b1, 8'hF0, 8'h3C, 0, 0, 1, 1, 0, 0, 0);
    idle();
    wait_out(2); lit("and_xor_merge", 1'b1, 8'hFC, 1'b0, 1'b0);
    wait_out(1); lit("no_op", 1'b1, 8'h00, 1'b0, 1'b0);

    // Leave cy=1, reset mid-stream, then chain: carry register must restart at 0.
    drive(1'b1, 8'hFF, 8'h01, 0, 0, 0, 0, 0, 0, 1);
    drive(1'b1, 8'h12, 8'h34, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    @(negedge clk); lit("reset_midstream", 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0, 1);
    idle();
    wait_out(3); lit("cy_cleared", 1'b1, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
      end
      if ($urandom_range(3) == 0) idle();
      else drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (S + 2) idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
